// File: rtl/response_tree_pipe_ic.sv
// N_SLAVE->1 response-routing tree with selectable per-level register stages,
// sticky same-cycle collision flag and a delivered-response counter.
module response_tree_pipe_ic #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned N_SLAVE    = 8,
    parameter int unsigned PIPE_MASK  = 8'h00,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SLAVE-1:0]            data_r_valid_i,
    input  logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic [N_SLAVE*ID_WIDTH-1:0]   data_r_ID_i,
    output logic                          data_r_valid_o,
    output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
    output logic [ID_WIDTH-1:0]           data_r_ID_o,
    input  logic                          collision_clr_i,
    output logic                          collision_o,
    output logic [CNT_WIDTH-1:0]          resp_cnt_o
);

    localparam int unsigned LOG_SLAVE = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 0;
    localparam int unsigned NP        = 1 << LOG_SLAVE;

    // Heap-indexed tree: node 1 is the root, nodes NP..2*NP-1 are the leaves,
    // node i combines children 2*i (lower index, wins) and 2*i+1.
    for (genvar i = 1; i < 2 * NP; i++) begin : g_node
        logic                  out_v;
        logic [DATA_WIDTH-1:0] out_d;
        logic [ID_WIDTH-1:0]   out_id;
        // Valid-only view of the current input cycle, so collisions are flagged
        // one edge after the offending inputs regardless of the pipeline depth.
        logic                  wave_v;
        logic                  coll_any;

        if (i >= NP) begin : g_leaf
            if (i - NP < N_SLAVE) begin : g_real
                assign out_v  = data_r_valid_i[i-NP];
                assign out_d  = data_r_rdata_i[(i-NP)*DATA_WIDTH +: DATA_WIDTH];
                assign out_id = data_r_ID_i[(i-NP)*ID_WIDTH +: ID_WIDTH];
            end else begin : g_pad
                assign out_v  = 1'b0;
                assign out_d  = '0;
                assign out_id = '0;
            end
            assign wave_v   = out_v;
            assign coll_any = 1'b0;
        end else begin : g_inner
            localparam int unsigned Lvl = LOG_SLAVE - $clog2(i + 1);

            logic                  mrg_v;
            logic [DATA_WIDTH-1:0] mrg_d;
            logic [ID_WIDTH-1:0]   mrg_id;

            assign mrg_v  = g_node[2*i].out_v | g_node[2*i+1].out_v;
            assign mrg_d  = g_node[2*i].out_v ? g_node[2*i].out_d  : g_node[2*i+1].out_d;
            assign mrg_id = g_node[2*i].out_v ? g_node[2*i].out_id : g_node[2*i+1].out_id;

            assign wave_v   = g_node[2*i].wave_v | g_node[2*i+1].wave_v;
            assign coll_any = (g_node[2*i].wave_v & g_node[2*i+1].wave_v) |
                              g_node[2*i].coll_any | g_node[2*i+1].coll_any;

            if (((PIPE_MASK >> Lvl) & 32'd1) != 0) begin : g_reg
                logic                  v_q;
                logic [DATA_WIDTH-1:0] d_q;
                logic [ID_WIDTH-1:0]   id_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v_q  <= 1'b0;
                        d_q  <= '0;
                        id_q <= '0;
                    end else begin
                        v_q <= mrg_v;
                        if (mrg_v) begin
                            d_q  <= mrg_d;
                            id_q <= mrg_id;
                        end
                    end
                end

                assign out_v  = v_q;
                assign out_d  = d_q;
                assign out_id = id_q;
            end else begin : g_comb
                assign out_v  = mrg_v;
                assign out_d  = mrg_d;
                assign out_id = mrg_id;
            end
        end
    end

    assign data_r_valid_o = g_node[1].out_v;
    assign data_r_rdata_o = g_node[1].out_d;
    assign data_r_ID_o    = g_node[1].out_id;

    logic                 collision_q;
    logic [CNT_WIDTH-1:0] resp_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_q <= 1'b0;
        end else if (g_node[1].coll_any) begin
            collision_q <= 1'b1;
        end else if (collision_clr_i) begin
            collision_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_cnt_q <= '0;
        end else if (data_r_valid_o) begin
            resp_cnt_q <= resp_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign collision_o = collision_q;
    assign resp_cnt_o  = resp_cnt_q;

endmodule

// File: tb/tb_response_tree_pipe_ic.sv
// Randomised bench for response_tree_pipe_ic: a main L=2 instance with directed
// scenarios plus a parameter sweep, all scored against a priority/delay-queue model.
module tb_response_tree_pipe_ic;

    typedef struct {
        bit          v;
        logic [31:0] d;
        logic [3:0]  id;
    } resp_t;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    logic clk = 1'b0;
    logic rst_m = 1'b1;
    logic rst_sw = 1'b1;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int sw_n(input int g);
        case (g / 2)
            0:       return 1;
            1:       return 3;
            2:       return 5;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int lat_of(input int n, input int m);
        int lg;
        int l;
        lg = (n > 1) ? $clog2(n) : 0;
        l  = 0;
        for (int b = 0; b < lg; b++) l += (m >> b) & 1;
        return l;
    endfunction

    // Main instance: N_SLAVE=8, PIPE_MASK=5 (L=2), 4-bit counter.
    localparam int ML = 2;

    logic [7:0]   m_vi;
    logic [255:0] m_di;
    logic [31:0]  m_idi;
    logic         m_clr;
    logic         m_vo;
    logic [31:0]  m_do;
    logic [3:0]   m_ido;
    logic         m_coll;
    logic [3:0]   m_cnt;

    response_tree_pipe_ic #(
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .N_SLAVE   (8),
        .PIPE_MASK (8'h05),
        .CNT_WIDTH (4)
    ) u_main (
        .clk            (clk),
        .rst            (rst_m),
        .data_r_valid_i (m_vi),
        .data_r_rdata_i (m_di),
        .data_r_ID_i    (m_idi),
        .data_r_valid_o (m_vo),
        .data_r_rdata_o (m_do),
        .data_r_ID_o    (m_ido),
        .collision_clr_i(m_clr),
        .collision_o    (m_coll),
        .resp_cnt_o     (m_cnt)
    );

    resp_t      m_q[$];
    logic [3:0] m_cnt_exp;
    bit         m_coll_exp;
    logic [7:0] m_last_vi;

    // One cycle: drive at negedge, then score the outputs against the model.
    task automatic m_step(input logic [7:0] vi, input logic [255:0] di,
                          input logic [31:0] idi, input logic clr);
        resp_t w;
        resp_t e;
        @(negedge clk);
        m_vi  = vi;
        m_di  = di;
        m_idi = idi;
        m_clr = clr;
        m_last_vi = vi;
        #1;
        w = '{1'b0, 32'h0, 4'h0};
        for (int b = 7; b >= 0; b--) if (vi[b]) w = '{1'b1, di[b*32 +: 32], idi[b*4 +: 4]};
        m_q.push_back(w);
        e = m_q.pop_front();
        check("m_valid", {31'h0, m_vo}, {31'h0, e.v});
        if (e.v) begin
            check("m_data", m_do, e.d);
            check("m_id", {28'h0, m_ido}, {28'h0, e.id});
        end
        check("m_cnt", {28'h0, m_cnt}, {28'h0, m_cnt_exp});
        check("m_coll", {31'h0, m_coll}, {31'h0, m_coll_exp});
        m_cnt_exp  = m_cnt_exp + {3'b0, e.v};
        m_coll_exp = ($countones(vi) >= 2) || (m_coll_exp && !clr);
    endtask

    task automatic m_idle(input int n);
        for (int j = 0; j < n; j++) m_step(8'h0, 256'h0, 32'h0, 1'b0);
    endtask

    task automatic m_one(input int bank, input logic [31:0] d, input logic [3:0] id);
        logic [7:0]   v;
        logic [255:0] dv;
        logic [31:0]  iv;
        v  = 8'h0;
        dv = 256'h0;
        iv = 32'h0;
        v[bank]          = 1'b1;
        dv[bank*32 +: 32] = d;
        iv[bank*4 +: 4]   = id;
        m_step(v, dv, iv, 1'b0);
    endtask

    // Asynchronous pulse between negedge and posedge; the current cycle's inputs
    // are still captured after release, older in-flight responses are lost.
    task automatic m_reset();
        #1 rst_m = 1'b1;
        #1;
        check("rst_valid", {31'h0, m_vo}, 32'h0);
        check("rst_data", m_do, 32'h0);
        check("rst_id", {28'h0, m_ido}, 32'h0);
        check("rst_coll", {31'h0, m_coll}, 32'h0);
        check("rst_cnt", {28'h0, m_cnt}, 32'h0);
        rst_m = 1'b0;
        for (int j = 0; j < m_q.size() - 1; j++) m_q[j] = '{1'b0, 32'h0, 4'h0};
        m_cnt_exp  = 4'h0;
        m_coll_exp = ($countones(m_last_vi) >= 2);
    endtask

    initial begin
        logic [7:0]   rv;
        logic [255:0] rd;
        logic [31:0]  ri;
        m_vi = 8'h0;
        m_di = 256'h0;
        m_idi = 32'h0;
        m_clr = 1'b0;
        m_last_vi = 8'h0;
        #1;
        check("init_valid", {31'h0, m_vo}, 32'h0);
        check("init_data", m_do, 32'h0);
        check("init_id", {28'h0, m_ido}, 32'h0);
        check("init_coll", {31'h0, m_coll}, 32'h0);
        check("init_cnt", {28'h0, m_cnt}, 32'h0);
        @(negedge clk);
        #2 rst_m = 1'b0;
        for (int j = 0; j < ML; j++) m_q.push_back('{1'b0, 32'h0, 4'h0});
        m_cnt_exp  = 4'h0;
        m_coll_exp = 1'b0;

        // Single response, visible at t+2 only
        m_one(5, 32'hDEADBEEF, 4'h3);
        m_idle(1);
        check("t1_early", {31'h0, m_vo}, 32'h0);
        m_idle(1);
        check("t1_valid", {31'h0, m_vo}, 32'h1);
        check("t1_data", m_do, 32'hDEADBEEF);
        check("t1_id", {28'h0, m_ido}, 32'h3);
        check("t1_coll", {31'h0, m_coll}, 32'h0);
        m_idle(1);
        check("t1_once", {31'h0, m_vo}, 32'h0);

        // Streaming banks 0..7 back to back
        m_reset();
        for (int b = 0; b < 8; b++) m_one(b, b, b[3:0]);
        m_idle(3);
        check("t2_cnt", {28'h0, m_cnt}, 32'h8);

        // Collision between banks 2 and 6
        m_reset();
        rd = 256'h0;
        ri = 32'h0;
        rd[2*32 +: 32] = 32'hAAAA0002;
        rd[6*32 +: 32] = 32'hBBBB0006;
        ri[2*4 +: 4] = 4'h2;
        ri[6*4 +: 4] = 4'h6;
        m_step(8'h44, rd, ri, 1'b0);
        m_idle(1);
        check("t3_coll_set", {31'h0, m_coll}, 32'h1);
        m_idle(1);
        check("t3_winner", m_do, 32'hAAAA0002);
        m_step(8'h03, {224'h0, 32'h12345678}, 32'h0, 1'b1);
        m_idle(1);
        check("t3_set_wins", {31'h0, m_coll}, 32'h1);
        m_step(8'h0, 256'h0, 32'h0, 1'b1);
        m_idle(1);
        check("t3_cleared", {31'h0, m_coll}, 32'h0);

        // Counter wrap after 17 responses
        m_reset();
        for (int j = 0; j < 17; j++) m_one($urandom_range(0, 7), $urandom, 4'($urandom_range(0, 15)));
        m_idle(3);
        check("t4_wrap", {28'h0, m_cnt}, 32'h1);

        // Reset while a response is in flight
        m_one(1, 32'hCAFEF00D, 4'h9);
        m_idle(1);
        m_reset();
        m_idle(1);
        check("t5_dropped", {31'h0, m_vo}, 32'h0);
        m_idle(2);
        check("t5_quiet", {31'h0, m_vo}, 32'h0);

        // Random traffic with occasional clears
        for (int k = 0; k < 200; k++) begin
            for (int b = 0; b < 8; b++) begin
                rv[b] = ($urandom_range(0, 7) == 0);
                rd[b*32 +: 32] = $urandom;
                ri[b*4 +: 4] = 4'($urandom_range(0, 15));
            end
            m_step(rv, rd, ri, ($urandom_range(0, 7) == 0));
        end
        m_idle(3);

        for (int i = 0; i < 2000 && n_done < 10; i++) @(negedge clk);
        check("sweep_done", n_done, 10);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial #22 rst_sw = 1'b0;

    // Parameter sweep: N_SLAVE in {1,3,5,8,16} x PIPE_MASK in {0, all-ones}
    for (genvar g = 0; g < 10; g++) begin : g_sw
        localparam int NS  = sw_n(g);
        localparam int PM  = (g % 2) ? 255 : 0;
        localparam int LAT = lat_of(NS, PM);

        logic [NS-1:0]    vi;
        logic [NS*32-1:0] di;
        logic [NS*4-1:0]  idi;
        logic             vo;
        logic [31:0]      dout;
        logic [3:0]       ido;
        logic             co;
        logic [15:0]      cnt;

        response_tree_pipe_ic #(
            .DATA_WIDTH(32),
            .ID_WIDTH  (4),
            .N_SLAVE   (NS),
            .PIPE_MASK (PM),
            .CNT_WIDTH (16)
        ) u_dut (
            .clk            (clk),
            .rst            (rst_sw),
            .data_r_valid_i (vi),
            .data_r_rdata_i (di),
            .data_r_ID_i    (idi),
            .data_r_valid_o (vo),
            .data_r_rdata_o (dout),
            .data_r_ID_o    (ido),
            .collision_clr_i(1'b0),
            .collision_o    (co),
            .resp_cnt_o     (cnt)
        );

        initial begin
            resp_t       q[$];
            resp_t       w;
            resp_t       e;
            logic [15:0] c_exp;
            bit          col_exp;
            string       pfx;
            pfx = $sformatf("sw_n%0d_m%0d", NS, PM);
            vi  = '0;
            di  = '0;
            idi = '0;
            c_exp   = 16'h0;
            col_exp = 1'b0;
            for (int j = 0; j < LAT; j++) q.push_back('{1'b0, 32'h0, 4'h0});
            wait (rst_sw == 1'b0);
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                for (int b = 0; b < NS; b++) begin
                    vi[b] = ($urandom_range(0, 3) == 0);
                    di[b*32 +: 32] = $urandom;
                    idi[b*4 +: 4] = 4'($urandom_range(0, 15));
                end
                #1;
                w = '{1'b0, 32'h0, 4'h0};
                for (int b = NS - 1; b >= 0; b--) if (vi[b]) w = '{1'b1, di[b*32 +: 32], idi[b*4 +: 4]};
                q.push_back(w);
                e = q.pop_front();
                check({pfx, "_valid"}, {31'h0, vo}, {31'h0, e.v});
                if (e.v) begin
                    check({pfx, "_data"}, dout, e.d);
                    check({pfx, "_id"}, {28'h0, ido}, {28'h0, e.id});
                end
                check({pfx, "_cnt"}, {16'h0, cnt}, {16'h0, c_exp});
                check({pfx, "_coll"}, {31'h0, co}, {31'h0, col_exp});
                c_exp   = c_exp + {15'h0, e.v};
                col_exp = col_exp || ($countones(vi) >= 2);
            end
            n_done++;
        end
    end

endmodule
